// File: rtl/bm_match_mac_pipe_if.sv
// Beat-level handshake bundle for the pipelined multiply/accumulate block.
// The master side feeds operands and takes results; the slave side is the MAC.
interface bm_match_mac_pipe_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 36,
  parameter int ACC_WIDTH = 64
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   a_in;
  logic [B_WIDTH-1:0]   b_in;
  logic                 signed_mode;
  logic                 acc_en;
  logic                 acc_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 overflow;

  modport master (
    output in_valid, a_in, b_in, signed_mode, acc_en, acc_clear, out_ready,
    input  in_ready, out_valid, out_data, overflow
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_mode, acc_en, acc_clear, out_ready,
    output in_ready, out_valid, out_data, overflow
  );
endinterface

// File: rtl/bm_match_mac_pipe.sv
// Full-precision signed/unsigned multiplier with optional accumulate, run through
// a LATENCY-register pipeline that stalls as a whole under output backpressure.
module bm_match_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 36,
  parameter int LATENCY   = 3,
  parameter int ACC_WIDTH = 64
) (
  input logic                clock,
  input logic                reset_n,
  bm_match_mac_pipe_if.slave bus
);

  localparam int PD  = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int MSB = ACC_WIDTH - 1;

  typedef struct packed {
    logic                 vld;
    logic                 sm;
    logic                 en;
    logic                 clr;
    logic [ACC_WIDTH-1:0] prod;
  } beat_t;

  logic                             adv;
  logic                             accept;
  logic signed [A_WIDTH:0]          a_x;
  logic signed [B_WIDTH:0]          b_x;
  logic signed [A_WIDTH+B_WIDTH+1:0] p_full;
  beat_t                            in_beat;
  beat_t                            head;
  beat_t                            stg [PD];

  logic                             out_valid_q;
  logic [ACC_WIDTH-1:0]             out_data_q;
  logic [ACC_WIDTH-1:0]             acc_q;
  logic                             ovf_q;
  logic [ACC_WIDTH:0]               sum_w;
  logic                             ovf_add;

  assign adv          = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & adv;
  assign bus.in_ready = adv;

  // One extra sign bit per operand lets a single signed multiply serve both modes.
  assign a_x    = {bus.signed_mode & bus.a_in[A_WIDTH-1], bus.a_in};
  assign b_x    = {bus.signed_mode & bus.b_in[B_WIDTH-1], bus.b_in};
  assign p_full = a_x * b_x;

  assign in_beat = '{vld:  accept,
                     sm:   bus.signed_mode,
                     en:   bus.acc_en,
                     clr:  bus.acc_clear,
                     prod: ACC_WIDTH'(p_full)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PD; i++) stg[i] <= '0;
    end else if (adv) begin
      stg[0] <= in_beat;
      for (int i = 1; i < PD; i++) stg[i] <= stg[i-1];
    end
  end

  // With a single stage the output register captures straight from the inputs.
  assign head = (LATENCY == 1) ? in_beat : stg[PD-1];

  assign sum_w   = {1'b0, acc_q} + {1'b0, head.prod};
  assign ovf_add = head.sm ? ((acc_q[MSB] == head.prod[MSB]) && (sum_w[MSB] != acc_q[MSB]))
                           : sum_w[ACC_WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= head.vld;
      if (head.vld) begin
        if (head.clr) begin
          acc_q      <= head.prod;
          out_data_q <= head.prod;
          ovf_q      <= 1'b0;
        end else if (head.en) begin
          acc_q      <= sum_w[MSB:0];
          out_data_q <= sum_w[MSB:0];
          ovf_q      <= ovf_q | ovf_add;
        end else begin
          out_data_q <= head.prod;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/bm_match_mac_pipe.md
Name: bm_match_mac_pipe

Overview:
- Parametrised successor to the fixed-width multiply primitive benchmarks.
- Computes a full-precision A_WIDTH x B_WIDTH product with per-beat signed or unsigned mode, through a LATENCY-stage pipeline with valid/ready backpressure.
- Has an optional accumulate mode with clear and a sticky overflow flag.
- Sits in the micro benchmark set to exercise hard-multiplier inference, pipelined DSP packing and accumulator chains in synthesis.

Parameters:
A_WIDTH, 18, operand A width (>=2)
B_WIDTH, 36, operand B width (>=2)
LATENCY, 3, pipeline stages from input accept to output register (>=1)
ACC_WIDTH, 64, accumulator/result width; must be >= A_WIDTH+B_WIDTH

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
a_in  input  A_WIDTH  operand A
b_in  input  B_WIDTH  operand B
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned (per beat)
acc_en  input  1  beat accumulates into the accumulator
acc_clear  input  1  beat restarts the accumulator with its own product
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
out_data  output  ACC_WIDTH  result
overflow  output  1  sticky accumulator overflow

Behaviour:
- Reset (reset_n=0, async): all stage valid bits 0, out_valid=0, out_data=0, accumulator=0, overflow=0; in_ready reflects the empty pipeline (=1) one the reset is released. Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational). A beat is accepted on an edge with in_valid & in_ready.
- When adv=1, every stage shifts one place. Stage 1 captures a_in, b_in, signed_mode, acc_en, acc_clear and in_valid&in_ready. When adv=0, the whole pipeline holds.
- Bubbles are not compressed.
- Latency: a beat accepted at edge k drives out_valid=1 after edge k+LATENCY, absent stalls. Sustained throughput is 1 beat/cycle while out_ready=1.
- Product P = A_WIDTH+B_WIDTH bits, never truncated.
  - signed_mode=1: operands sign-extended, product sign-extended to ACC_WIDTH.
  - signed_mode=0: zero-extended.
  - The product register may sit at any stage <= LATENCY; the retiming choice is free.
- Output stage update on the edge a valid beat enters it:
  - acc_clear=1 (takes priority over acc_en): acc = ext(P); out_data = ext(P); overflow cleared.
  - acc_en=1, acc_clear=0: acc = acc + ext(P) mod 2^ACC_WIDTH; out_data = new acc. overflow set if:
    - unsigned: a carry out of ACC_WIDTH occurs;
    - signed: both addends have the same sign and the sum's sign differs.
  - Neither set: out_data = ext(P); acc unchanged.
- Overflow is sticky until a clear beat or reset. Signedness for overflow is that of the current beat.
- Bubbles entering the output stage leave acc, overflow and out_data unchanged. out_data holds while out_valid=1 and out_ready=0.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

Test Plan:
- Unsigned, LATENCY=3: a=255, b=255, signed_mode=0, out_ready=1 -> out_valid exactly 3 cycles after accept, out_data=65025.
- Signed: a=18'h3FFFF (-1), b=3, signed_mode=1 -> out_data = -3 (all ones except bit0=1, bit1=0 over 64 bits). Same operands with signed_mode=0 -> 786429.
- Accumulate: beats (2*3 clear), (4*5 acc_en), (1*1 acc_en), (7*7 none) -> outputs 6, 26, 27, 49; a following acc_en beat 1*1 -> 28.
- Backpressure: stream 6 beats with out_ready low for 4 cycles mid-stream -> in_ready=0 while out_valid&!out_ready; no beat lost or duplicated, order preserved, out_data stable during stall.
- Overflow with A_WIDTH=B_WIDTH=4, ACC_WIDTH=8, unsigned: clear 15*15 (225), acc_en 15*15 -> out_data=194, overflow=1; next clear beat 1*1 -> overflow=0.
- Reset mid-operation: assert reset_n=0 with 3 beats in flight -> out_valid=0 and out_data=0 immediately (async); after release, no stale beat emerges and a new beat 2*2 yields 4 at normal latency.
